fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
Instruction-fetch stage of the pipelined MIPS datapath. It owns the program counter and drives the combinational instruction memory's address input. It captures the returned word into the IF/ID pipeline register. It handles hazard stalls, branch/jump redirects with wrong-path flush, and address-error detection, and it keeps a retired-fetch counter for debug.

Parameters:
RESET_PC, 32'h0000_0000, byte address loaded into the PC on reset
NOP_INSTR, 32'h0000_0000, bubble word (sll $0,$0,0) written to IF/ID on flush or invalid fetch
IMEM_DEPTH_WORDS, 1024, instruction memory depth in 32-bit words; valid byte range is 0 .. 4*IMEM_DEPTH_WORDS-4

Ports:
Clk  input  1  rising-edge clock
Reset  input  1  synchronous, active-low reset
StallIF  input  1  from hazard unit; hold PC and IF/ID
RedirectValid  input  1  taken branch/jump resolved downstream
RedirectTarget  input  32  byte address of redirect target
InstructionIn  input  32  word from instruction memory for the current PCOut (combinational, same cycle)
PCOut  output  32  current PC; drives the instruction memory address
InstructionID  output  32  IF/ID instruction
PCPlus4ID  output  32  IF/ID PC+4 of that instruction
ValidID  output  1  IF/ID holds a real instruction
MisalignedError  output  1  sticky; a redirect target had bits [1:0] != 0
RangeError  output  1  sticky; a fetch was attempted at PC >= 4*IMEM_DEPTH_WORDS
FetchCount  output  32  count of valid instructions written into IF/ID, saturating at 32'hFFFF_FFFF

Behaviour:
- All state updates on the rising edge of Clk. Reset is sampled only on that edge.
- Priority each edge: Reset low > RedirectValid > StallIF > normal advance.
- Reset low:
  - PC <= RESET_PC; InstructionID <= NOP_INSTR; PCPlus4ID <= 0; ValidID <= 0.
  - MisalignedError, RangeError and FetchCount <= 0.
  - Reset asserted mid-stall or mid-redirect discards everything.
- Redirect (RedirectValid=1):
  - PC <= {RedirectTarget[31:2],2'b00}.
  - MisalignedError <= 1 if RedirectTarget[1:0] != 0.
  - IF/ID flushed: InstructionID <= NOP_INSTR, ValidID <= 0, PCPlus4ID <= 0.
  - FetchCount unchanged. StallIF is ignored on the same edge.
- Stall (StallIF=1, no redirect): PC, IF/ID contents, FetchCount and error flags all hold.
- Normal advance:
  - PC <= PC+4, 32-bit modulo; wrap from FFFF_FFFC to 0 is legal.
  - PCPlus4ID <= PC+4.
  - If PC is in range: InstructionID <= InstructionIn, ValidID <= 1, FetchCount += 1 (saturating).
  - If PC is out of range: InstructionID <= NOP_INSTR, ValidID <= 0, RangeError <= 1, FetchCount unchanged.
- In-range test is combinational on PC: PC < 4*IMEM_DEPTH_WORDS.
- PCOut is the PC register itself, with no combinational path from inputs.
- Latency: the word at address A appears on InstructionID one edge after PCOut==A with no stall or redirect. After a redirect, one bubble precedes the first target instruction.
- Error flags clear only on reset.

Decomposition:
- Shared package mips_pkg holds:
  - NOP_INSTR
  - RESET_PC
  - WORD_BYTES=4
  - instruction/address widths (32)
- One natural sub-module, if_id_register, holds the IF/ID register with stall-hold and flush-to-NOP controls (instruction, PC+4, valid).
- fetch_stage keeps the PC, next-PC mux, range/alignment checks, error flags and counter.

Test Plan:
1. Reset: mem[0]=20080005, mem[1]=2009000A; hold Reset low 2 edges, then release.
   -> Before the first advance: PCOut=0, ValidID=0, InstructionID=0.
   -> Edge 1: PCOut=4, InstructionID=20080005, PCPlus4ID=4, ValidID=1, FetchCount=1.
   -> Edge 2: InstructionID=2009000A, PCPlus4ID=8.
2. Stall: at PCOut=8, hold StallIF high for 2 edges.
   -> PCOut stays 8; InstructionID stays 2009000A; FetchCount stays 2.
   -> On release, next edge: PCOut=C, InstructionID=mem[2].
3. Redirect: at PCOut=10, RedirectValid=1, RedirectTarget=40.
   -> Next edge: PCOut=40, InstructionID=0, ValidID=0, FetchCount unchanged.
   -> Following edge: InstructionID=mem[16], PCPlus4ID=44.
4. Redirect and stall together: RedirectValid=1, StallIF=1, target=80.
   -> Redirect wins: PCOut=80, IF/ID flushed.
   -> Misaligned target 42: PCOut=40, MisalignedError=1; it stays 1 over 10 later edges until Reset.
5. Out of range (IMEM_DEPTH_WORDS=1024): redirect to 1000.
   -> Next advance: InstructionID=0, ValidID=0, RangeError=1, PCOut=1004, FetchCount unchanged.
6. Reset mid-operation: drive Reset low while StallIF=1, with both error flags set and FetchCount=5.
   -> After that edge: PCOut=0, all IF/ID fields 0, both errors 0, FetchCount=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths, reset/bubble constants and the IF/ID payload type for the MIPS pipeline.
package mips_pkg;

  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;  // sll $0,$0,0

  typedef logic [INSTR_W-1:0] instr_t;
  typedef logic [ADDR_W-1:0]  addr_t;

  // One IF/ID pipeline entry
  typedef struct packed {
    instr_t instr;
    addr_t  pc_plus4;
    logic   valid;
  } if_id_t;

endpackage : mips_pkg

// File: rtl/if_id_register.sv
// IF/ID pipeline register with stall-hold and flush-to-bubble controls.
module if_id_register
  import mips_pkg::*;
#(
  parameter instr_t NOP = mips_pkg::NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   stall,
  input  logic   flush,
  input  if_id_t fetch_in,
  output if_id_t if_id_out
);

  if_id_t if_id_q;
  if_id_t if_id_d;

  // Flush beats stall; an invalid fetch is captured as a bubble but keeps its PC+4
  always_comb begin
    if_id_d = if_id_q;
    if (flush) begin
      if_id_d.instr    = NOP;
      if_id_d.pc_plus4 = '0;
      if_id_d.valid    = 1'b0;
    end else if (!stall) begin
      if_id_d.instr    = fetch_in.valid ? fetch_in.instr : NOP;
      if_id_d.pc_plus4 = fetch_in.pc_plus4;
      if_id_d.valid    = fetch_in.valid;
    end
  end

  // Register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_id_q.instr    <= NOP;
      if_id_q.pc_plus4 <= '0;
      if_id_q.valid    <= 1'b0;
    end else begin
      if_id_q <= if_id_d;
    end
  end

  assign if_id_out = if_id_q;

endmodule : if_id_register

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, redirect/stall control, range and alignment checks, fetch counter.
module fetch_stage #(
  parameter logic [31:0] RESET_PC         = mips_pkg::RESET_PC,
  parameter logic [31:0] NOP_INSTR        = mips_pkg::NOP_INSTR,
  parameter int unsigned IMEM_DEPTH_WORDS = 1024
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallIF,
  input  logic        RedirectValid,
  input  logic [31:0] RedirectTarget,
  input  logic [31:0] InstructionIn,
  output logic [31:0] PCOut,
  output logic [31:0] InstructionID,
  output logic [31:0] PCPlus4ID,
  output logic        ValidID,
  output logic        MisalignedError,
  output logic        RangeError,
  output logic [31:0] FetchCount
);

  import mips_pkg::*;

  // One past the last fetchable byte; 33 bits so large depths cannot overflow
  localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [31:0] CNT_MAX    = 32'hFFFF_FFFF;

  addr_t       pc_q, pc_d;
  logic        mis_err_q, mis_err_d;
  logic        rng_err_q, rng_err_d;
  logic [31:0] fetch_cnt_q, fetch_cnt_d;

  addr_t       pc_plus4_c;
  logic        in_range_c;
  if_id_t      fetch_in_c;
  if_id_t      if_id_c;

  // Sequential PC address and the in-range test on the current PC
  always_comb begin
    pc_plus4_c = pc_q + 32'(WORD_BYTES);
    in_range_c = ({1'b0, pc_q} < IMEM_LIMIT);
  end

  // Next PC, sticky error flags and saturating fetch counter; redirect outranks stall
  always_comb begin
    pc_d        = pc_q;
    mis_err_d   = mis_err_q;
    rng_err_d   = rng_err_q;
    fetch_cnt_d = fetch_cnt_q;
    if (RedirectValid) begin
      pc_d = {RedirectTarget[31:2], 2'b00};
      if (RedirectTarget[1:0] != 2'b00) begin
        mis_err_d = 1'b1;
      end
    end else if (!StallIF) begin
      pc_d = pc_plus4_c;
      if (in_range_c) begin
        if (fetch_cnt_q != CNT_MAX) begin
          fetch_cnt_d = fetch_cnt_q + 32'd1;
        end
      end else begin
        rng_err_d = 1'b1;
      end
    end
  end

  // PC, flags and counter registers with synchronous active-low reset
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      pc_q        <= RESET_PC;
      mis_err_q   <= 1'b0;
      rng_err_q   <= 1'b0;
      fetch_cnt_q <= '0;
    end else begin
      pc_q        <= pc_d;
      mis_err_q   <= mis_err_d;
      rng_err_q   <= rng_err_d;
      fetch_cnt_q <= fetch_cnt_d;
    end
  end

  // Payload offered to IF/ID this cycle
  always_comb begin
    fetch_in_c.instr    = InstructionIn;
    fetch_in_c.pc_plus4 = pc_plus4_c;
    fetch_in_c.valid    = in_range_c;
  end

  if_id_register #(
    .NOP (NOP_INSTR)
  ) u_if_id (
    .clk       (Clk),
    .rst_n     (Reset),
    .stall     (StallIF),
    .flush     (RedirectValid),
    .fetch_in  (fetch_in_c),
    .if_id_out (if_id_c)
  );

  assign PCOut           = pc_q;
  assign InstructionID   = if_id_c.instr;
  assign PCPlus4ID       = if_id_c.pc_plus4;
  assign ValidID         = if_id_c.valid;
  assign MisalignedError = mis_err_q;
  assign RangeError      = rng_err_q;
  assign FetchCount      = fetch_cnt_q;

endmodule : fetch_stage

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios then randomized stall/redirect/reset traffic.
module tb_fetch_stage;

  localparam int unsigned DEPTH   = 1024;
  localparam logic [31:0] LIMIT   = 32'd4096;
  localparam logic [31:0] GARBAGE = 32'hBADC_0DE0;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        stall_if;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] instr_in;
  logic [31:0] pc_out;
  logic [31:0] instr_id;
  logic [31:0] pc_plus4_id;
  logic        valid_id;
  logic        mis_err;
  logic        rng_err;
  logic [31:0] fetch_count;

  logic [31:0] mem [DEPTH];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic        rng;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb[$];

  // Reference model state (architectural view of the stage)
  exp_t m;

  int checks   = 0;
  int failures = 0;

  fetch_stage dut (
    .Clk             (clk),
    .Reset           (reset_n),
    .StallIF         (stall_if),
    .RedirectValid   (redirect_valid),
    .RedirectTarget  (redirect_target),
    .InstructionIn   (instr_in),
    .PCOut           (pc_out),
    .InstructionID   (instr_id),
    .PCPlus4ID       (pc_plus4_id),
    .ValidID         (valid_id),
    .MisalignedError (mis_err),
    .RangeError      (rng_err),
    .FetchCount      (fetch_count)
  );

  always #5 clk = ~clk;

  // Combinational instruction memory; out-of-range addresses return junk
  assign instr_in = (pc_out < LIMIT) ? mem[pc_out[11:2]] : GARBAGE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Apply inputs for one edge, advance the model, record the expected post-edge state
  task automatic step(input logic rst, input logic stall, input logic redir,
                      input logic [31:0] tgt);
    reset_n         = rst;
    stall_if        = stall;
    redirect_valid  = redir;
    redirect_target = tgt;
    if (!rst) begin
      m.pc = 32'h0; m.instr = 32'h0; m.pc4 = 32'h0; m.valid = 1'b0;
      m.mis = 1'b0; m.rng = 1'b0; m.cnt = 32'h0;
    end else if (redir) begin
      m.pc    = tgt & ~32'h3;
      m.mis   = m.mis | (tgt % 4 != 0);
      m.instr = 32'h0; m.valid = 1'b0; m.pc4 = 32'h0;
    end else if (!stall) begin
      if (m.pc < LIMIT) begin
        m.instr = mem[m.pc / 4];
        m.valid = 1'b1;
        if (m.cnt != 32'hFFFF_FFFF) m.cnt = m.cnt + 1;
      end else begin
        m.instr = 32'h0;
        m.valid = 1'b0;
        m.rng   = 1'b1;
      end
      m.pc4 = m.pc + 4;
      m.pc  = m.pc + 4;
    end
    @(posedge clk);
    sb.push_back(m);
    #1;
  endtask

  task automatic adv(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  // Monitor: compare the DUT against the oldest expectation away from the active edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      chk("pc",        pc_out,              e.pc);
      chk("instr_id",  instr_id,            e.instr);
      chk("pcplus4",   pc_plus4_id,         e.pc4);
      chk("valid_id",  32'(valid_id),       32'(e.valid));
      chk("misalign",  32'(mis_err),        32'(e.mis));
      chk("range_err", 32'(rng_err),        32'(e.rng));
      chk("fetch_cnt", fetch_count,         e.cnt);
    end
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "simulation time limit");
  end

  initial begin
    int kind;
    logic [31:0] tgt;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_000A;

    reset_n = 1'b0; stall_if = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
    #2;

    // Reset held for two edges, then straight-line fetch
    step(1'b0, 1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0);
    adv(2);
    // Stall at PC=8 for two edges, then release
    step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    adv(2);
    // Redirect at PC=0x10 to 0x40, bubble then target word
    step(1'b1, 1'b0, 1'b1, 32'h40);
    adv(1);
    // Redirect and stall together: redirect wins
    step(1'b1, 1'b1, 1'b1, 32'h80);
    // Misaligned target, flag stays set
    step(1'b1, 1'b0, 1'b1, 32'h42);
    adv(10);
    step(1'b1, 1'b1, 1'b0, 32'h0);
    // Out of range fetch
    step(1'b1, 1'b0, 1'b1, 32'h1000);
    adv(2);
    // Reset while stalled with both flags set
    step(1'b0, 1'b1, 1'b0, 32'h0);
    adv(3);
    // Last in-range word, then first out-of-range address
    step(1'b1, 1'b0, 1'b1, 32'hFF8);
    adv(3);
    // PC wraps from FFFF_FFFC to 0 and resumes valid fetches
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFF8);
    adv(4);

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 2) begin
        step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      end else if (kind < 12) begin
        case ($urandom_range(0, 9))
          7:       tgt = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'($urandom_range(1, 3))};
          8:       tgt = LIMIT - 32'd8 + 32'($urandom_range(0, 3) * 4);
          9:       tgt = $urandom;
          default: tgt = {20'h0, 10'($urandom_range(0, DEPTH - 1)), 2'b00};
        endcase
        step(1'b1, 1'($urandom_range(0, 1)), 1'b1, tgt);
      end else if (kind < 37) begin
        step(1'b1, 1'b1, 1'b0, $urandom);
      end else begin
        step(1'b1, 1'b0, 1'b0, $urandom);
      end
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    @(posedge clk);
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_fetch_stage
